// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M unit: single-pass multiplier and radix-2 restoring divider.
// Holds the pipeline via md_stall while an op is in flight and presents the result in DONE.
module ex_muldiv_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned FUNCT7_WIDTH = 7,
  parameter int unsigned FUNCT3_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode_E,
  input  logic [FUNCT7_WIDTH-1:0] funct7_E,
  input  logic [FUNCT3_WIDTH-1:0] funct3_E,
  input  logic [XLEN-1:0]         srcA_E,
  input  logic [XLEN-1:0]         srcB_E,
  input  logic                    hold_E,
  output logic                    md_stall,
  output logic                    md_valid,
  output logic [XLEN-1:0]         md_result
);

  localparam int unsigned CNT_W = 6;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [FUNCT7_WIDTH-1:0] F7_MULDIV  = FUNCT7_WIDTH'(7'b0000001);
  localparam logic [XLEN-1:0]         INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [XLEN-1:0]         a_q, a_d, b_q, b_d;
  logic [FUNCT3_WIDTH-1:0] op_q, op_d;
  logic [XLEN-1:0]         quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN-1:0]         result_q, result_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    is_md;
  logic                    start_signed;
  logic                    a_signed, b_signed;
  logic [2*XLEN-1:0]       mul_a, mul_b, prod;
  logic                    div_signed, div_by_zero, div_ovf;
  logic [XLEN:0]           rem_sh, diff;
  logic                    q_bit;
  logic [XLEN-1:0]         quo_n, rem_n, quo_fin, rem_fin;

  assign is_md     = (opcode_E == OPC_OP) && (funct7_E == F7_MULDIV);
  assign md_stall  = ((state_q == S_IDLE) && is_md) || (state_q == S_MUL) || (state_q == S_DIV);
  assign md_valid  = (state_q == S_DONE);
  assign md_result = result_q;

  // Product of the latched operands; MULH/MULHSU sign-extend rs1, only MULH sign-extends rs2.
  always_comb begin
    a_signed = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
    b_signed = (op_q[1:0] == 2'b01);
    mul_a    = {{XLEN{a_signed & a_q[XLEN-1]}}, a_q};
    mul_b    = {{XLEN{b_signed & b_q[XLEN-1]}}, b_q};
    prod     = mul_a * mul_b;
  end

  // One restoring shift-subtract step on magnitudes, plus final sign fix-up.
  always_comb begin
    start_signed = ~funct3_E[0];
    div_signed   = ~op_q[0];
    div_by_zero  = (b_q == '0);
    div_ovf      = div_signed && (a_q == INT_MIN) && (b_q == '1);
    rem_sh       = {rem_q, quo_q[XLEN-1]};
    diff         = rem_sh - {1'b0, dvs_q};
    q_bit        = ~diff[XLEN];
    rem_n        = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_n        = {quo_q[XLEN-2:0], q_bit};
    quo_fin      = (div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_n : quo_n;
    rem_fin      = (div_signed && a_q[XLEN-1]) ? -rem_n : rem_n;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (is_md) begin
          // Forwarded operands may change while stalled, so capture them now.
          a_d     = srcA_E;
          b_d     = srcB_E;
          op_d    = funct3_E;
          quo_d   = (start_signed && srcA_E[XLEN-1]) ? -srcA_E : srcA_E;
          dvs_d   = (start_signed && srcB_E[XLEN-1]) ? -srcB_E : srcB_E;
          rem_d   = '0;
          cnt_d   = CNT_W'(XLEN-1);
          state_d = funct3_E[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        result_d = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        state_d  = S_DONE;
      end
      S_DIV: begin
        if (div_by_zero) begin
          result_d = op_q[1] ? a_q : '1;
          state_d  = S_DONE;
        end else if (div_ovf) begin
          result_d = op_q[1] ? '0 : INT_MIN;
          state_d  = S_DONE;
        end else begin
          quo_d = quo_n;
          rem_d = rem_n;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            result_d = op_q[1] ? rem_fin : quo_fin;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!hold_E) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed and random M-ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode_E, funct7_E;
  logic [2:0]  funct3_E;
  logic [31:0] srcA_E, srcB_E;
  logic        hold_E;
  logic        md_stall, md_valid;
  logic [31:0] md_result;

  int errors = 0;
  int checks = 0;

  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .opcode_E(opcode_E), .funct7_E(funct7_E), .funct3_E(funct3_E),
    .srcA_E(srcA_E), .srcB_E(srcB_E), .hold_E(hold_E),
    .md_stall(md_stall), .md_valid(md_valid), .md_result(md_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p, ua, ub;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub;                 return p[31:0];  end
      3'd1: begin p = 64'(sa * sb);            return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub));  return p[63:32]; end
      3'd3: begin p = ua * ub;                 return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_stalls(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 2;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 33;
  endfunction

  task automatic drive_bubble();
    opcode_E = '0; funct7_E = '0; funct3_E = '0;
  endtask

  // Issue one M-op into E, wait for DONE, check result/latency, optionally hold in DONE.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, input int hold_n);
    int          stalls, cycles;
    logic [31:0] r0;
    @(negedge clk);
    opcode_E = 7'b0110011; funct7_E = 7'b0000001; funct3_E = f3;
    srcA_E = a; srcB_E = b;
    #1;
    stalls = 0; cycles = 0;
    while (!md_valid && cycles < 60) begin
      if (md_stall) stalls++;
      @(negedge clk);
      if (scramble) begin srcA_E = $urandom; srcB_E = $urandom; end
      #1;
      cycles++;
    end
    check($sformatf("valid f3=%0d a=%h b=%h", f3, a, b), 32'(md_valid), 32'd1);
    check($sformatf("result f3=%0d a=%h b=%h", f3, a, b), md_result, ref_md(f3, a, b));
    check($sformatf("stalls f3=%0d a=%h b=%h", f3, a, b), 32'(stalls), 32'(ref_stalls(f3, a, b)));
    check("stall_in_done", 32'(md_stall), 32'd0);
    if (hold_n > 0) begin
      r0 = md_result;
      hold_E = 1'b1;
      for (int k = 0; k < hold_n; k++) begin
        @(negedge clk);
        #1;
        check("hold_valid", 32'(md_valid), 32'd1);
        check("hold_stall", 32'(md_stall), 32'd0);
        check("hold_result", md_result, r0);
      end
      hold_E = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    drive_bubble();
    #1;
    check({tag, "_stall"}, 32'(md_stall), 32'd0);
    check({tag, "_valid"}, 32'(md_valid), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          mode;

    rst = 1'b1; hold_E = 1'b0; srcA_E = '0; srcB_E = '0;
    drive_bubble();
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", 32'(md_stall), 32'd0);
    check("reset_valid", 32'(md_valid), 32'd0);
    check("reset_result", md_result, 32'd0);
    rst = 1'b0;

    // Non-M R-type must not engage the unit.
    @(negedge clk);
    opcode_E = 7'b0110011; funct7_E = 7'b0000000; funct3_E = 3'd0; srcA_E = 32'd5; srcB_E = 32'd6;
    #1;
    check("nonm_stall", 32'(md_stall), 32'd0);
    check("nonm_valid", 32'(md_valid), 32'd0);

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    do_op(3'd5, 32'd100, 32'd7, 1'b0, 0);
    do_op(3'd7, 32'd100, 32'd7, 1'b0, 0);
    do_op(3'd4, 32'd5, 32'd0, 1'b0, 0);
    do_op(3'd7, 32'd5, 32'd0, 1'b0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(3'd5, 32'd100, 32'd7, 1'b1, 0);
    do_op(3'd1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 4);
    idle_check("after_hold");

    // Back-to-back MUL then DIVU with no bubble between them.
    do_op(3'd0, 32'd12345, 32'd678, 1'b0, 0);
    do_op(3'd5, 32'hFFFF_FFFF, 32'd3, 1'b0, 0);
    idle_check("b2b_end");

    // Reset in the middle of a divide.
    @(negedge clk);
    opcode_E = 7'b0110011; funct7_E = 7'b0000001; funct3_E = 3'd4; srcA_E = 32'd1000; srcB_E = 32'd3;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    drive_bubble();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_stall", 32'(md_stall), 32'd0);
    check("midrst_valid", 32'(md_valid), 32'd0);
    check("midrst_result", md_result, 32'd0);
    do_op(3'd6, 32'd1000, 32'd3, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 5);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 15));
      do_op(f3, a, b, 1'($urandom_range(0, 1)), (i % 6 == 0) ? 2 : 0);
    end
    idle_check("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Execute-stage RV32M unit. Consumes the decoded instruction and forwarded operands held in the ID/EX register, and produces a result for the EX/MEM register.
- MUL/MULH/MULHSU/MULHU complete in 2 extra cycles. DIV/DIVU/REM/REMU use a radix-2 iterative divider with XLEN extra cycles.
- While an op is in flight, md_stall is raised so the hazard unit holds F, D and E and bubbles M.

Parameters:
- XLEN, 32, operand/result width.
- OPCODE_WIDTH, 7, opcode field width.
- FUNCT7_WIDTH, 7, funct7 field width.
- FUNCT3_WIDTH, 3, funct3 field width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- opcode_E  input  OPCODE_WIDTH  opcode of the instruction in E.
- funct7_E  input  FUNCT7_WIDTH  funct7 of the instruction in E.
- funct3_E  input  FUNCT3_WIDTH  funct3 selecting MUL(000), MULH(001), MULHSU(010), MULHU(011), DIV(100), DIVU(101), REM(110), REMU(111).
- srcA_E  input  XLEN  forwarded rs1 value.
- srcB_E  input  XLEN  forwarded rs2 value.
- hold_E  input  1  ID/EX is held this cycle by a stall source other than md_stall.
- md_stall  output  1  op in E not yet complete; hazard unit stalls F/D/E.
- md_valid  output  1  md_result is valid for the instruction in E.
- md_result  output  XLEN  result routed into the EX/MEM ALU-result mux.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, md_valid=0, md_result=0, all internal registers cleared. md_stall=0 as soon as state is IDLE. rst mid-operation aborts the operation with no residual effect.
- is_md = (opcode_E==7'b0110011) && (funct7_E==7'b0000001). A flushed bubble (all-zero fields) never matches.
- States:
  - IDLE: if is_md, md_stall=1 combinationally. At the edge, latch srcA_E, srcB_E and funct3_E. Latching is required because forwarded values may change while stalled. Next state: MUL if funct3[2]=0; DIV otherwise. Otherwise stay IDLE, md_stall=0.
  - MUL: md_stall=1. Register the 64-bit product. Operands are sign-extended per op: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned×unsigned (low word is identical). The result is the low word for MUL and the high word otherwise. Next state: DONE.
  - DIV (entry cycle): if divisor==0, or signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF), write the special result and go to DONE the next cycle. Otherwise iterate.
  - DIV (iteration): restoring shift-subtract on magnitudes, one quotient bit per cycle, 6-bit counter from XLEN-1 down to 0, md_stall=1. When the counter reaches 0, apply signs and go to DONE.
  - DONE: md_stall=0, md_valid=1, md_result=latched result. If hold_E=1, stay in DONE with the result stable and no restart. If hold_E=0, return to IDLE; the instruction advances at this edge.
- Latency (cycles in E, no external hold):
  - MUL ops: 3 (2 stall cycles).
  - Normal DIV ops: XLEN+2 = 34 (33 stall cycles).
  - Divide-by-zero or overflow: 3.
- Special results (RISC-V):
  - DIV/DIVU by 0 → 0xFFFFFFFF.
  - REM/REMU by 0 → dividend.
  - DIV overflow → 0x80000000.
  - REM overflow → 0.
- Sign rules: the quotient is negated iff the operand signs differ (signed ops only). The remainder takes the sign of the dividend.
- Back-to-back: a new M-op arriving the cycle after DONE is in IDLE and starts normally, so there is no stall gap or overlap.
- Non-M instructions in E: outputs md_stall=0, md_valid=0. md_result holds its last value (don't-care).

Test Plan:
- MUL srcA=7, srcB=0xFFFFFFFD (−3) → md_stall high for 2 cycles, then md_valid=1, md_result=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD, with exactly 33 stall cycles. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0. Each completes in 3 cycles.
- Change srcA_E/srcB_E every cycle during a DIVU 100/7 → result is still 14.
- hold_E=1 for 4 cycles in DONE → md_valid stays 1, md_result is stable, md_stall stays 0, no restart. After hold_E falls → IDLE.
- Back-to-back MUL then DIVU: correct results, no lost cycle. Assert rst at iteration 10 of a DIV → next cycle IDLE, md_stall=0, md_valid=0, md_result=0.
